pc_ctrl: RTL and testbench

Next-PC control block: drives the `ps_in`, `ia_in` and `ra_in` inputs of `pc` from decoded control-flow events and consumes `pc_out` as its current-PC input. It owns the return-address stack (RAS) that supplies call/return targets. It sits between the instruction decoder and `pc`, and forms the producing end of the PC-select interface.

---
 rtl/mycpu_pkg.sv | 22 ++
 rtl/ras_mem.sv | 69 ++++++
 rtl/pc_ctrl.sv | 118 +++++++++++
 tb/tb_pc_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// ============================================================================
// Module : mycpu_pkg
// Brief  : Shared PC-select encoding and default widths for the PC datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mycpu_pkg;

  typedef enum logic [1:0] {
    PS_INC  = 2'b00,
    PS_JUMP = 2'b01,
    PS_RET  = 2'b10,
    PS_HOLD = 2'b11
  } ps_t;

  localparam int RAS_DEPTH_DEF = 4;
  localparam int ADDR_W        = 16;

endpackage : mycpu_pkg

`default_nettype wire

// File: rtl/ras_mem.sv
// ============================================================================
// Module : ras_mem
// Brief  : Circular return-address stack with top pointer and entry count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_mem
  import mycpu_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int AW    = ADDR_W,
  parameter int SPW   = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] top,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [CW-1:0]  r_cnt;
  logic [SPW-1:0] w_sp_inc;
  logic [SPW-1:0] w_sp_dec;

  // Power-of-two depth lets the pointer wrap by plain overflow.
  assign w_sp_inc = r_sp + SPW'(1);
  assign w_sp_dec = r_sp - SPW'(1);

  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign top   = r_mem[r_sp];
  assign cnt   = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push) begin
      // A full stack overwrites its oldest entry, which sits at sp+1.
      r_mem[w_sp_inc] <= wdata;
      r_sp            <= w_sp_inc;
      if (!full) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (pop) begin
      if (!empty) begin
        r_sp  <= w_sp_dec;
        r_cnt <= r_cnt - CW'(1);
      end
    end else if (replace) begin
      r_mem[r_sp] <= wdata;
    end
  end

endmodule : ras_mem

`default_nettype wire

// File: rtl/pc_ctrl.sv
// ============================================================================
// Module : pc_ctrl
// Brief  : Next-PC select decode, return-address stack and sticky error flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_ctrl
  import mycpu_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int AW        = ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AW-1:0]                pc_in,
  input  logic                         stall_in,
  input  logic                         jump_in,
  input  logic                         call_in,
  input  logic                         ret_in,
  input  logic [AW-1:0]                target_in,
  output logic [1:0]                   ps_out,
  output logic [AW-1:0]                ia_out,
  output logic [AW-1:0]                ra_out,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt_out,
  output logic                         ovf_out,
  output logic                         unf_out
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  ps_t           w_ps;
  logic          w_push;
  logic          w_pop;
  logic          w_replace;
  logic          w_set_ovf;
  logic          w_set_unf;
  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_top;
  logic [CW-1:0] w_cnt;
  logic [AW-1:0] w_ret_addr;
  logic          r_ovf;
  logic          r_unf;

  assign w_ret_addr = pc_in + AW'(1);

  always_comb begin
    w_ps      = PS_INC;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_replace = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (rst || stall_in) begin
      w_ps = PS_HOLD;
    end else if (call_in && ret_in) begin
      // Tail call: return to the current top and reuse its slot for the new link.
      if (!w_empty) begin
        w_ps      = PS_RET;
        w_replace = 1'b1;
      end else begin
        w_ps      = PS_JUMP;
        w_push    = 1'b1;
        w_set_unf = 1'b1;
      end
    end else if (call_in) begin
      w_ps      = PS_JUMP;
      w_push    = 1'b1;
      w_set_ovf = w_full;
    end else if (ret_in) begin
      if (!w_empty) begin
        w_ps  = PS_RET;
        w_pop = 1'b1;
      end else begin
        w_set_unf = 1'b1;
      end
    end else if (jump_in) begin
      w_ps = PS_JUMP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  ras_mem #(
    .DEPTH (RAS_DEPTH),
    .AW    (AW)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .replace (w_replace),
    .wdata   (w_ret_addr),
    .top     (w_top),
    .cnt     (w_cnt),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign ps_out      = w_ps;
  assign ia_out      = target_in;
  assign ra_out      = w_top;
  assign ras_cnt_out = w_cnt;
  assign ovf_out     = r_ovf;
  assign unf_out     = r_unf;

endmodule : pc_ctrl

`default_nettype wire

// File: tb/tb_pc_ctrl.sv
// ============================================================================
// Module : tb_pc_ctrl
// Brief  : Directed vector bench for pc_ctrl with hand-computed expectations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in;
  logic        stall_in, jump_in, call_in, ret_in;
  logic [15:0] target_in;
  logic [1:0]  ps_out;
  logic [15:0] ia_out, ra_out;
  logic [2:0]  ras_cnt_out;
  logic        ovf_out, unf_out;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        st, ca, re, ju;
    logic [15:0] pc, tg;
    logic [1:0]  ps;    // expected select before the edge
    logic [15:0] ra;    // expected ra_out before the edge
    logic [2:0]  cnt;   // expected count after the edge
    logic        ovf, unf;
  } vec_t;

  vec_t vecs[$];

  pc_ctrl #(.RAS_DEPTH(4), .AW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .stall_in    (stall_in),
    .jump_in     (jump_in),
    .call_in     (call_in),
    .ret_in      (ret_in),
    .target_in   (target_in),
    .ps_out      (ps_out),
    .ia_out      (ia_out),
    .ra_out      (ra_out),
    .ras_cnt_out (ras_cnt_out),
    .ovf_out     (ovf_out),
    .unf_out     (unf_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, ca, re, ju, input logic [15:0] pc, tg,
                     input logic [1:0] ps, input logic [15:0] ra,
                     input logic [2:0] cnt, input logic ovf, unf);
    vec_t v;
    v.st = st; v.ca = ca; v.re = re; v.ju = ju; v.pc = pc; v.tg = tg;
    v.ps = ps; v.ra = ra; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, ca, re, ju, input logic [15:0] pc, tg);
    stall_in = st; call_in = ca; ret_in = re; jump_in = ju;
    pc_in = pc; target_in = tg;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 16'h0010, 16'h0000);

    // st ca re ju   pc       tg       ps     ra_pre   cnt ovf unf
    add(0, 1, 0, 0, 16'h0010, 16'h0200, 2'b01, 16'h0000, 1, 0, 0);
    add(0, 0, 1, 0, 16'h0200, 16'h0000, 2'b10, 16'h0011, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0100, 2'b01, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 0, 16'h0001, 16'h0100, 2'b01, 16'h0001, 2, 0, 0);
    add(0, 1, 0, 0, 16'h0002, 16'h0100, 2'b01, 16'h0002, 3, 0, 0);
    add(0, 1, 0, 0, 16'h0003, 16'h0100, 2'b01, 16'h0003, 4, 0, 0);
    add(0, 1, 0, 0, 16'h0004, 16'h0100, 2'b01, 16'h0004, 4, 1, 0);
    add(0, 0, 1, 0, 16'h0100, 16'h0000, 2'b10, 16'h0005, 3, 1, 0);
    add(0, 0, 1, 0, 16'h0005, 16'h0000, 2'b10, 16'h0004, 2, 1, 0);
    add(0, 0, 1, 0, 16'h0004, 16'h0000, 2'b10, 16'h0003, 1, 1, 0);
    add(0, 0, 1, 0, 16'h0003, 16'h0000, 2'b10, 16'h0002, 0, 1, 0);
    add(0, 0, 1, 0, 16'h0002, 16'h0000, 2'b00, 16'h0005, 0, 1, 1);
    add(0, 0, 0, 1, 16'h0020, 16'h0400, 2'b01, 16'h0005, 0, 1, 1);
    add(0, 0, 0, 0, 16'h0021, 16'h0000, 2'b00, 16'h0005, 0, 1, 1);
    add(0, 1, 0, 0, 16'h0010, 16'h0200, 2'b01, 16'h0005, 1, 1, 1);
    add(0, 1, 1, 0, 16'h0300, 16'h0500, 2'b10, 16'h0011, 1, 1, 1);
    add(1, 1, 0, 0, 16'h0301, 16'h0600, 2'b11, 16'h0301, 1, 1, 1);
    add(0, 0, 1, 0, 16'h0400, 16'h0000, 2'b10, 16'h0301, 0, 1, 1);
    add(0, 1, 1, 0, 16'h1000, 16'h0700, 2'b01, 16'h0005, 1, 1, 1);
    add(0, 1, 0, 0, 16'hFFFF, 16'h0800, 2'b01, 16'h1001, 2, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 2, 1, 1);

    // Reset state and select forced to hold while reset is high.
    repeat (2) @(negedge clk);
    chk("rst_ps", 32'(ps_out), 32'(2'b11));
    chk("rst_ra", 32'(ra_out), 32'h0);
    chk("rst_cnt", 32'(ras_cnt_out), 32'h0);
    chk("rst_flags", {30'b0, ovf_out, unf_out}, 32'h0);
    rst = 1'b0;
    #1;
    chk("idle_ps", 32'(ps_out), 32'(2'b00));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].ca, vecs[i].re, vecs[i].ju, vecs[i].pc, vecs[i].tg);
      #1;
      chk($sformatf("v%0d_ps", i), 32'(ps_out), 32'(vecs[i].ps));
      chk($sformatf("v%0d_ia", i), 32'(ia_out), 32'(vecs[i].tg));
      chk($sformatf("v%0d_ra", i), 32'(ra_out), 32'(vecs[i].ra));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", i), 32'(ras_cnt_out), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_ovf", i), 32'(ovf_out), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(unf_out), 32'(vecs[i].unf));
    end

    // Asynchronous reset between edges while a call is presented.
    @(negedge clk);
    drive(0, 1, 0, 0, 16'h0050, 16'h0900);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(ras_cnt_out), 32'h0);
    chk("arst_flags", {30'b0, ovf_out, unf_out}, 32'h0);
    chk("arst_ra", 32'(ra_out), 32'h0);
    chk("arst_ps", 32'(ps_out), 32'(2'b11));
    @(posedge clk);
    #1;
    chk("arst_nopush", 32'(ras_cnt_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Tail call on an empty stack acts as a call and flags underflow.
    drive(0, 1, 1, 0, 16'h0070, 16'h0A00);
    #1;
    chk("tc_empty_ps", 32'(ps_out), 32'(2'b01));
    @(posedge clk);
    #1;
    chk("tc_empty_cnt", 32'(ras_cnt_out), 32'h1);
    chk("tc_empty_ra", 32'(ra_out), 32'h0071);
    chk("tc_empty_flags", {30'b0, ovf_out, unf_out}, 32'h1);

    // Call immediately followed by return hands back the fresh link.
    @(negedge clk);
    drive(0, 1, 0, 0, 16'h0123, 16'h0B00);
    @(negedge clk);
    drive(0, 0, 1, 0, 16'h0B00, 16'h0000);
    #1;
    chk("cr_ps", 32'(ps_out), 32'(2'b10));
    chk("cr_ra", 32'(ra_out), 32'h0124);
    @(posedge clk);
    #1;
    chk("cr_cnt", 32'(ras_cnt_out), 32'h1);
    chk("cr_ra_after", 32'(ra_out), 32'h0071);

    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pc_ctrl

`default_nettype wire
